hog_bank_scheduler: RTL
=======================

# hog_bank_scheduler

Sequencer for the four-bank HOG pixel store (four `bram_d81920` banks with a shared read address). It runs once per frame:
- **Write phase:** takes a row-major pixel stream and scatters it across the banks in a 2x2 interleave.
- **Read phase:** issues one shared read address per cycle, so the gradient/cell stage receives a full 2x2 pixel quad every cycle.

It also holds off writes while the RAMs report reset-busy, and signals frame completion.

## Interface
- `RAM_AW`, 17, bank address width
- `QN`, 8, pixel width
- `IMG_W`, 640, frame width in pixels (even)
- `IMG_H`, 512, frame height in pixels (even)
- `RD_LAT`, 2, BRAM read latency in cycles (≥1)

Ports:
- `clk` in 1 — single clock for the block and all banks
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — one-cycle frame start request
- `ram_busy` in 1 — OR of the bank `rsta_busy`/`rstb_busy` flags
- `pix_valid` in 1, `pix_data` in QN, `pix_ready` out 1 — pixel stream handshake
- `wea` out 4, `ena` out 4 — per-bank write strobes; bit k drives bank k+1
- `wr_addr` out RAM_AW, `wr_data` out QN — shared write address/data, fanned out to all banks
- `enb` out 1, `rd_addr` out RAM_AW — shared read enable/address
- `rd_en` in 1 — consumer permits one quad issue this cycle
- `db0`..`db3` in QN each — bank read data
- `q_valid` out 1, `q00`,`q01`,`q10`,`q11` out QN each — quad output (row,col offsets)
- `q_x` out RAM_AW, `q_y` out RAM_AW — quad column and row index
- `busy` out 1 — high in any state other than IDLE
- `done` out 1 — one-cycle frame-complete pulse

## Operation
- **State machine:** IDLE → WAIT_RDY → WRITE → READ → DRAIN → IDLE.
- **IDLE:**
  - `start` moves to WAIT_RDY.
  - `start` is ignored in every other state.
- **WAIT_RDY:** go to WRITE in the first cycle in which `ram_busy`=0.
- **WRITE:**
  - `pix_ready`=1 in this state only.
  - A beat is accepted when `pix_valid && pix_ready`.
  - Pixel at (row r, col c) goes to bank b = {r[0],c[0]} at address (r>>1)*(IMG_W/2)+(c>>1).
  - r and c advance per accepted beat; c wraps at IMG_W-1 and r then increments.
  - After the IMG_W*IMG_H-th beat, go to READ. `pix_ready` falls in the following cycle.
- **READ:**
  - `enb`=1.
  - In each cycle with `rd_en`=1, issue address qy*(IMG_W/2)+qx and advance qx/qy in row-major order over (IMG_W/2)x(IMG_H/2) quads.
  - After the last quad is issued, go to DRAIN.
- **DRAIN:**
  - `enb`=1 for RD_LAT cycles.
  - Then pulse `done` and return to IDLE.
- **Read output mapping:**
  - `q00`=db0, `q01`=db1, `q10`=db2, `q11`=db3 (pass-through).
  - `q_valid`, `q_x` and `q_y` are carried through a delay line that shifts every cycle, independent of `rd_en`.
- **Address arithmetic:**
  - Unsigned, computed at RAM_AW bits.
  - (IMG_W/2)*(IMG_H/2) ≤ 2^RAM_AW is a parameter requirement and is not checked in logic.
- **Reset** (at any time, including mid-frame):
  - All outputs go to 0, state goes to IDLE, and all counters and the delay line are cleared.
  - Partial frame contents in the RAMs are abandoned.
- **Boundary cases:**
  - `pix_valid`=0 stalls writes without losing position.
  - `rd_en`=0 produces no issue; the address holds and no `q_valid` is generated for that cycle.
  - `start` in the same cycle as `done` is ignored.

## Timing
- **Write path:**
  - A beat accepted in cycle t appears on `wea`/`ena` (one-hot), `wr_addr` and `wr_data` in cycle t+1, registered.
  - When no beat is accepted, `wea`=`ena`=0.
- **Read path:**
  - An issue in cycle c drives registered `rd_addr` in cycle c+1.
  - Bank data is valid in cycle c+1+RD_LAT.
  - `q_valid`, `q_x` and `q_y` are asserted in that same cycle.
- **Throughput:** up to one pixel per cycle during write, and one quad per cycle during read.
- **Phase boundary:** the first READ issue can occur in the cycle after the final WRITE beat. The final write completes before any read reaches the same address.
- **`done` timing:** `done` is asserted RD_LAT cycles after the last quad's `rd_addr` is driven. This is coincident with or after the last `q_valid`.
- **Reset values:** `pix_ready`, `wea`, `ena`, `wr_addr`, `wr_data`, `enb`, `rd_addr`, `q_valid`, `q_x`, `q_y`, `busy` and `done` are all 0.

## Test plan
- **Write scatter.** IMG_W=8, IMG_H=4, `pix_data`=index 0..31 streamed back-to-back.
  - Pixel 9 (r1,c1) gives `wea`=4'b1000 with `wr_addr`=0.
  - Pixel 14 (r1,c6) gives `wea`=4'b0100 with `wr_addr`=3.
  - Exactly 32 strobes in total.
- **Quad readback.** Same frame with a behavioural RAM model at RD_LAT=2 and `rd_en`=1.
  - 8 quads out, the first being {0,1,8,9} at (0,0).
  - The last is {22,23,30,31} at (3,1).
  - `done` is asserted exactly once.
- **Busy hold-off.** `ram_busy`=1 for 10 cycles after `start`.
  - `pix_ready` stays 0 until the cycle after `ram_busy` falls.
- **Stalls.** Randomly toggle `pix_valid` and `rd_en` at 50%.
  - The output quad sequence is identical to the no-stall case.
  - No `q_valid` is generated for `rd_en`=0 cycles.
- **Mid-frame reset.** Assert `rst_n` low during WRITE at beat 13.
  - All outputs read 0 while reset is held.
  - A new `start` restarts at pixel (0,0) and bank 0, address 0.
- **Ignored start.** Pulse `start` during READ.
  - No state change, and exactly one `done` for the frame.

Source files
------------

// File: rtl/hog_bank_scheduler.sv
// Frame sequencer for the four-bank HOG pixel store: scatters a row-major pixel
// stream into a 2x2 bank interleave, then reads one full pixel quad per cycle.
module hog_bank_scheduler #(
  parameter int RAM_AW = 17,
  parameter int QN     = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 512,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ram_busy,
  input  logic              pix_valid,
  input  logic [QN-1:0]     pix_data,
  output logic              pix_ready,
  output logic [3:0]        wea,
  output logic [3:0]        ena,
  output logic [RAM_AW-1:0] wr_addr,
  output logic [QN-1:0]     wr_data,
  output logic              enb,
  output logic [RAM_AW-1:0] rd_addr,
  input  logic              rd_en,
  input  logic [QN-1:0]     db0,
  input  logic [QN-1:0]     db1,
  input  logic [QN-1:0]     db2,
  input  logic [QN-1:0]     db3,
  output logic              q_valid,
  output logic [QN-1:0]     q00,
  output logic [QN-1:0]     q01,
  output logic [QN-1:0]     q10,
  output logic [QN-1:0]     q11,
  output logic [RAM_AW-1:0] q_x,
  output logic [RAM_AW-1:0] q_y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, WRITE, READ, DRAIN} state_t;

  localparam logic [RAM_AW-1:0] HALF_W   = RAM_AW'(IMG_W / 2);
  localparam logic [RAM_AW-1:0] LAST_COL = RAM_AW'(IMG_W - 1);
  localparam logic [RAM_AW-1:0] LAST_ROW = RAM_AW'(IMG_H - 1);
  localparam logic [RAM_AW-1:0] LAST_QX  = RAM_AW'(IMG_W / 2 - 1);
  localparam logic [RAM_AW-1:0] LAST_QY  = RAM_AW'(IMG_H / 2 - 1);
  localparam int                DW       = $clog2(RD_LAT + 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT);

  state_t            state_reg, state_next;
  logic [RAM_AW-1:0] col_reg, row_reg, qx_reg, qy_reg;
  logic [DW-1:0]     drain_cnt_reg;
  logic [3:0]        strobe_reg;
  logic              accept, last_pix, issue, last_quad;

  assign accept    = pix_valid && pix_ready;
  assign last_pix  = accept && (col_reg == LAST_COL) && (row_reg == LAST_ROW);
  assign issue     = (state_reg == READ) && rd_en;
  assign last_quad = issue && (qx_reg == LAST_QX) && (qy_reg == LAST_QY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // done is decoded in the last DRAIN cycle so a coincident start is still ignored
  always_comb begin
    state_next = state_reg;
    pix_ready  = 1'b0;
    enb        = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:     if (start) state_next = WAIT_RDY;
      WAIT_RDY: if (!ram_busy) state_next = WRITE;
      WRITE: begin
        pix_ready = 1'b1;
        if (last_pix) state_next = READ;
      end
      READ: begin
        enb = 1'b1;
        if (last_quad) state_next = DRAIN;
      end
      DRAIN: begin
        enb = (drain_cnt_reg < DRAIN_LAST);
        if (drain_cnt_reg == DRAIN_LAST) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      qx_reg        <= '0;
      qy_reg        <= '0;
      drain_cnt_reg <= '0;
      strobe_reg    <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      rd_addr       <= '0;
    end else begin
      strobe_reg    <= '0;
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + DW'(1) : '0;
      if (state_reg == IDLE && start) begin
        col_reg <= '0;
        row_reg <= '0;
        qx_reg  <= '0;
        qy_reg  <= '0;
      end
      if (accept) begin
        strobe_reg <= 4'b0001 << {row_reg[0], col_reg[0]};
        wr_addr    <= ((row_reg >> 1) * HALF_W) + (col_reg >> 1);
        wr_data    <= pix_data;
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (issue) begin
        rd_addr <= (qy_reg * HALF_W) + qx_reg;
        if (qx_reg == LAST_QX) begin
          qx_reg <= '0;
          qy_reg <= (qy_reg == LAST_QY) ? '0 : qy_reg + 1'b1;
        end else begin
          qx_reg <= qx_reg + 1'b1;
        end
      end
    end
  end

  assign wea = strobe_reg;
  assign ena = strobe_reg;

  // Stage 0 mirrors rd_addr timing; stage RD_LAT lines up with bank data.
  logic              dl_valid [RD_LAT+1];
  logic [RAM_AW-1:0] dl_x     [RD_LAT+1];
  logic [RAM_AW-1:0] dl_y     [RD_LAT+1];

  generate
    for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dl_valid[gi] <= 1'b0;
            dl_x[gi]     <= '0;
            dl_y[gi]     <= '0;
          end else begin
            dl_valid[gi] <= issue;
            dl_x[gi]     <= qx_reg;
            dl_y[gi]     <= qy_reg;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dl_valid[gi] <= 1'b0;
            dl_x[gi]     <= '0;
            dl_y[gi]     <= '0;
          end else begin
            dl_valid[gi] <= dl_valid[gi-1];
            dl_x[gi]     <= dl_x[gi-1];
            dl_y[gi]     <= dl_y[gi-1];
          end
        end
      end
    end
  endgenerate

  assign q_valid = dl_valid[RD_LAT];
  assign q_x     = dl_x[RD_LAT];
  assign q_y     = dl_y[RD_LAT];
  assign q00     = db0;
  assign q01     = db1;
  assign q10     = db2;
  assign q11     = db3;

endmodule
